// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and opcodes for the multicycle MIPS controller
// Contents: aluop_t (ALU operation to the ALU decoder), state_t (controller states),
// ctrl_t (packed control word), opcode localparams OP_*.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    aluop_t     aluop;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller <-> datapath/memory signal bundle
// Modport ctrl: controller side (inputs op, zero, mem_ready; drives all control outputs).
// Modport dp: datapath/memory side (the mirror image).
interface mc_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [2:0] aluop;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;

  modport ctrl (
    input  op, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, imm_zext, aluop, reg_dst, mem_to_reg, reg_write, illegal_op
  );

  modport dp (
    output op, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, imm_zext, aluop, reg_dst, mem_to_reg, reg_write, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state/op/zero/mem_ready to control word decode
// Inputs: state, op, zero, mem_ready. Output: ctrl (ctrl_t control word).
// Macro MC_CTRL_BNE_EN: branch pc_en uses ~zero when op is bne.
module mc_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALU_SUB;
        ctrl.pc_src    = 2'b01;
`ifdef MC_CTRL_BNE_EN
        ctrl.pc_en     = (op == OP_BNE) ? ~zero : zero;
`else
        ctrl.pc_en     = zero;
`endif
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin
            ctrl.aluop    = ALU_AND;
            ctrl.imm_zext = 1'b1;
          end
          OP_ORI: begin
            ctrl.aluop    = ALU_OR;
            ctrl.imm_zext = 1'b1;
          end
          default: ctrl.aluop = ALU_ADD;
        endcase
      end
      S_IMMWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src = 2'b10;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS main controller (state register, next state, illegal_op)
// Ports: clk, rst_n (async active-low), bus (mc_ctrl_if.ctrl: op/zero/mem_ready in, controls out).
// Parameter RESET_STATE: state entered on reset (S_FETCH).
// Macro MC_CTRL_BNE_EN: accept bne (000101) as a branch; otherwise it is illegal.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  mc_ctrl_if.ctrl    bus
);

  state_t state;
  state_t state_nxt;
  logic   illegal_q;
  logic   illegal_nxt;
  ctrl_t  ctrl;

  always_comb begin
    state_nxt   = S_FETCH;
    illegal_nxt = 1'b0;
    case (state)
      S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:              state_nxt = S_MEMADR;
          OP_RTYPE:                  state_nxt = S_EXEC;
          OP_BEQ:                    state_nxt = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:                    state_nxt = S_BRANCH;
`endif
          OP_ADDI, OP_ANDI, OP_ORI:  state_nxt = S_IMMEX;
          OP_J:                      state_nxt = S_JUMP;
          default:                   illegal_nxt = 1'b1;
        endcase
      end
      S_MEMADR: state_nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_IMMEX:  state_nxt = S_IMMWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .op        (bus.op),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.iord       = ctrl.iord;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.pc_en      = ctrl.pc_en;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.imm_zext   = ctrl.imm_zext;
  assign bus.aluop      = ctrl.aluop;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.illegal_op = illegal_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle main controller for the MIPS datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives datapath mux selects and write enables.
- Produces the 3-bit aluop consumed by the existing ALU decoder.
- Stalls on a simple memory ready handshake.

Parameters:
- RESET_STATE, 4'd0 (S_FETCH), state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from instruction register; stable from S_DECODE until next S_FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe (qualifies mem_req)
- iord  out  1  0=PC address, 1=ALUOut address
- ir_write  out  1  load instruction register
- pc_en  out  1  PC write enable
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=imm, 11=imm<<2
- imm_zext  out  1  1=zero-extend immediate (andi/ori)
- aluop  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=memory data
- reg_write  out  1  register file write
- illegal_op  out  1  registered one-cycle pulse on unknown opcode

Behaviour:
- One 4-bit state register. Async reset to S_FETCH; illegal_op resets to 0.
- All other outputs decode combinationally from state, plus mem_ready, zero and op where noted.
- Every output not listed for a state is 0, except alu_src_b, which is 00 unless listed.
- In reset (S_FETCH), outputs are:
  - mem_req=1, alu_src_b=01, aluop=000, pc_src=00, iord=0
  - ir_write=pc_en=mem_ready
  - all other outputs 0
- S_FETCH(0):
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=000, pc_src=00
  - ir_write=pc_en=mem_ready
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- S_DECODE(1):
  - alu_src_a=0, alu_src_b=11, aluop=000
  - Next state by op:
    - lw 100011 or sw 101011 -> S_MEMADR
    - 000000 -> S_EXEC
    - beq 000100 -> S_BRANCH
    - addi 001000, andi 001100, ori 001101 -> S_IMMEX
    - j 000010 -> S_JUMP
    - any other op -> S_FETCH, and illegal_op=1 on the following cycle
- S_MEMADR(2): alu_src_a=1, alu_src_b=10, aluop=000. Next S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD(3): mem_req=1, iord=1. Holds until mem_ready, then S_MEMWB.
- S_MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Next S_FETCH.
- S_MEMWR(5): mem_req=1, mem_write=1, iord=1. Holds until mem_ready, then S_FETCH.
- S_EXEC(6): alu_src_a=1, alu_src_b=00, aluop=010. Next S_ALUWB.
- S_ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next S_FETCH.
- S_BRANCH(8): alu_src_a=1, alu_src_b=00, aluop=001, pc_src=01, pc_en=zero. Next S_FETCH.
- S_IMMEX(9): alu_src_a=1, alu_src_b=10.
  - aluop=000 for addi, 011 for andi, 100 for ori.
  - imm_zext=1 for andi/ori.
  - Next S_IMMWB.
- S_IMMWB(10): reg_write=1, reg_dst=0, mem_to_reg=0. Next S_FETCH.
- S_JUMP(11): pc_src=10, pc_en=1. Next S_FETCH.
- Unused encodings 12-15 -> S_FETCH next cycle, all outputs 0.
- Reset asserted mid-instruction: immediate return to S_FETCH; any pending memory access is abandoned; memory must tolerate mem_req being dropped.
- mem_ready outside S_FETCH/S_MEMRD/S_MEMWR is ignored.
- CPI is fixed apart from memory stalls: lw 5, sw 4, R-type 4, imm 4, beq 3, j 3, illegal 2.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- Defined: op 000101 (bne) in S_DECODE -> S_BRANCH. In S_BRANCH, pc_en = zero for beq and ~zero for bne; all other branch outputs unchanged.
- Undefined: 000101 is illegal (S_FETCH and an illegal_op pulse).

Decomposition:
- mips_pkg holds:
  - aluop_t enum (ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR)
  - state_t enum with the encodings above
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J
- One sub-module, mc_ctrl_outdec: purely combinational state/op/zero/mem_ready -> control word. mc_ctrl keeps the state register, next-state logic and the illegal_op flop.

Test Plan:
- Reset with rst_n low, mem_ready=1 -> S_FETCH, mem_req=1, alu_src_b=01, ir_write=pc_en=1, illegal_op=0. Assert rst_n in S_MEMRD -> S_FETCH with no clock edge.
- lw, memory ready after 3 wait cycles in both fetch and read -> S_FETCH held 4 cycles, S_MEMRD held 4 cycles, reg_write=1 with mem_to_reg=1 in S_MEMWB; total 11 cycles.
- R-type (op 000000) -> aluop=010 in S_EXEC, reg_dst=1 and reg_write=1 in S_ALUWB; back in S_FETCH at cycle 4.
- beq: zero=1 -> pc_en=1, pc_src=01; zero=0 -> pc_en=0. With MC_CTRL_BNE_EN, bne gives the inverse pc_en.
- andi/ori/addi -> aluop 011/100/000 with imm_zext 1/1/0. j -> pc_src=10, pc_en=1.
- op 111111 -> S_DECODE then S_FETCH, with illegal_op high exactly one cycle.
